// File: rtl/uart_apb_ctrl_if.sv
// APB bus bundle between the UART echo sequencer (master) and the UART (slave).
interface uart_apb_ctrl_if;
  logic        psel;
  logic        penable;
  logic [2:0]  pprot;
  logic [31:0] paddr;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready;
  logic        pslverr;
  logic [31:0] prdata;

  modport master (
    output psel, penable, pprot, paddr, pwrite, pwdata, pstrb,
    input  pready, pslverr, prdata
  );

  modport slave (
    input  psel, penable, pprot, paddr, pwrite, pwdata, pstrb,
    output pready, pslverr, prdata
  );
endinterface

// File: rtl/uart_apb_ctrl.sv
// APB master that configures the UART after reset and then echoes every
// received byte back out, reporting progress and errors for debug pins.
//
// state      | meaning
// -----------+-------------------------------------------------------
// S_CFG_DIV  | write baud divisor to DIV (0xC)
// S_CFG_CTRL | write tx_en|rx_en to CTRL (0x8)
// S_RUN_WAIT | bus idle; count poll gap, wait for en
// S_POLL_RX  | read STATUS (0x4), look at rx_valid
// S_READ_RX  | read DATA (0x0), capture RX byte
// S_POLL_TX  | read STATUS (0x4), look at tx_full
// S_TX_GAP   | bus idle between TX-space polls
// S_WRITE_TX | write captured byte to DATA (0x0)
// S_ERROR    | bus idle, terminal until reset
module uart_apb_ctrl #(
  parameter logic [15:0] DIV_RESET = 16'd104,
  parameter int          POLL_GAP  = 8,
  parameter int          TIMEOUT   = 64
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   en,
  uart_apb_ctrl_if.master        apb,
  output logic                   cfg_done,
  output logic                   busy,
  output logic                   err,
  output logic [7:0]             err_cnt,
  output logic [15:0]            byte_cnt
);

  // Counters are loaded with N-1 so that exactly N cycles elapse before
  // the terminal count of zero is seen.
  localparam int GW = (POLL_GAP < 2) ? 1 : $clog2(POLL_GAP);
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam int GAP_LOAD_I = (POLL_GAP > 0) ? POLL_GAP - 1 : 0;
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_LOAD_I);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_CFG_DIV, S_CFG_CTRL, S_RUN_WAIT, S_POLL_RX, S_READ_RX,
    S_POLL_TX, S_TX_GAP, S_WRITE_TX, S_ERROR
  } state_t;

  state_t         state_q, state_d;
  logic           access_q, access_d;
  logic [GW-1:0]  gap_q, gap_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic [7:0]     byte_q, byte_d;
  logic           cfg_done_q, cfg_done_d;
  logic           err_q, err_d;
  logic [7:0]     err_cnt_q, err_cnt_d;
  logic [15:0]    byte_cnt_q, byte_cnt_d;

  logic           bus_sel;
  logic [3:0]     bus_addr;
  logic           bus_wr;
  logic [31:0]    bus_wdata;
  logic           unused_prdata;

  assign unused_prdata = ^apb.prdata[31:8];

  // Register update with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= S_CFG_DIV;
      access_q   <= 1'b0;
      gap_q      <= '0;
      tmo_q      <= '0;
      byte_q     <= 8'h00;
      cfg_done_q <= 1'b0;
      err_q      <= 1'b0;
      err_cnt_q  <= 8'h00;
      byte_cnt_q <= 16'h0000;
    end else begin
      state_q    <= state_d;
      access_q   <= access_d;
      gap_q      <= gap_d;
      tmo_q      <= tmo_d;
      byte_q     <= byte_d;
      cfg_done_q <= cfg_done_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  // Bus request decode: every bus state presents a fixed transfer.
  always_comb begin
    bus_sel   = 1'b0;
    bus_addr  = 4'h0;
    bus_wr    = 1'b0;
    bus_wdata = 32'h0;
    case (state_q)
      S_CFG_DIV:  begin bus_sel = 1'b1; bus_addr = 4'hC; bus_wr = 1'b1; bus_wdata = {16'h0, DIV_RESET}; end
      S_CFG_CTRL: begin bus_sel = 1'b1; bus_addr = 4'h8; bus_wr = 1'b1; bus_wdata = 32'h3; end
      S_POLL_RX:  begin bus_sel = 1'b1; bus_addr = 4'h4; end
      S_READ_RX:  begin bus_sel = 1'b1; bus_addr = 4'h0; end
      S_POLL_TX:  begin bus_sel = 1'b1; bus_addr = 4'h4; end
      S_WRITE_TX: begin bus_sel = 1'b1; bus_addr = 4'h0; bus_wr = 1'b1; bus_wdata = {24'h0, byte_q}; end
      default:    ;
    endcase
  end

  // Next-state: setup/access sequencing, timeout, completion handling.
  always_comb begin
    state_d    = state_q;
    access_d   = access_q;
    gap_d      = gap_q;
    tmo_d      = tmo_q;
    byte_d     = byte_q;
    cfg_done_d = cfg_done_q;
    err_d      = err_q;
    err_cnt_d  = err_cnt_q;
    byte_cnt_d = byte_cnt_q;

    if (bus_sel) begin
      if (!access_q) begin
        access_d = 1'b1;
        tmo_d    = TMO_LOAD;
      end else if (apb.pready) begin
        access_d = 1'b0;
        if (apb.pslverr) begin
          if (state_q == S_CFG_DIV || state_q == S_CFG_CTRL) begin
            err_d   = 1'b1;
            state_d = S_ERROR;
          end else begin
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
            state_d = S_RUN_WAIT;
            gap_d   = GAP_LOAD;
          end
        end else begin
          case (state_q)
            S_CFG_DIV: state_d = S_CFG_CTRL;
            S_CFG_CTRL: begin
              cfg_done_d = 1'b1;
              state_d    = S_RUN_WAIT;
              gap_d      = GAP_LOAD;
            end
            S_POLL_RX: begin
              if (apb.prdata[0]) begin
                state_d = S_READ_RX;
              end else begin
                state_d = S_RUN_WAIT;
                gap_d   = GAP_LOAD;
              end
            end
            S_READ_RX: begin
              byte_d  = apb.prdata[7:0];
              state_d = S_POLL_TX;
            end
            S_POLL_TX: begin
              if (!apb.prdata[1]) begin
                state_d = S_WRITE_TX;
              end else if (POLL_GAP == 0) begin
                state_d = S_POLL_TX;
              end else begin
                state_d = S_TX_GAP;
                gap_d   = GAP_LOAD;
              end
            end
            S_WRITE_TX: begin
              byte_cnt_d = byte_cnt_q + 16'd1;
              state_d    = S_RUN_WAIT;
              gap_d      = GAP_LOAD;
            end
            default: ;
          endcase
        end
      end else if (tmo_q == '0) begin
        access_d = 1'b0;
        err_d    = 1'b1;
        state_d  = S_ERROR;
      end else begin
        tmo_d = tmo_q - TW'(1);
      end
    end else begin
      case (state_q)
        S_RUN_WAIT: begin
          if (gap_q != '0) gap_d = gap_q - GW'(1);
          else if (en)     state_d = S_POLL_RX;
        end
        S_TX_GAP: begin
          if (gap_q != '0) gap_d = gap_q - GW'(1);
          else             state_d = S_POLL_TX;
        end
        default: ;
      endcase
    end
  end

  // Outputs are forced low combinationally so a reset mid-transfer drops
  // the bus in the same cycle rather than at the next edge.
  assign apb.psel    = resetn & bus_sel;
  assign apb.penable = resetn & bus_sel & access_q;
  assign apb.pprot   = 3'b000;
  assign apb.paddr   = resetn ? {28'h0, bus_addr} : 32'h0;
  assign apb.pwrite  = resetn & bus_wr;
  assign apb.pwdata  = resetn ? bus_wdata : 32'h0;
  assign apb.pstrb   = (resetn & bus_wr) ? 4'hF : 4'h0;

  assign busy     = resetn & bus_sel;
  assign cfg_done = resetn & cfg_done_q;
  assign err      = resetn & err_q;
  assign err_cnt  = resetn ? err_cnt_q : 8'h00;
  assign byte_cnt = resetn ? byte_cnt_q : 16'h0000;

endmodule

// File: tb/tb_uart_apb_ctrl.sv
// Bench for the UART echo sequencer: an APB slave model serves responses
// from a scoreboard queue and checks each transfer against its expectation.
module tb_uart_apb_ctrl;
  localparam int          POLL_GAP = 8;
  localparam int          TIMEOUT  = 64;
  localparam logic [15:0] DIV      = 16'd104;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        en = 1'b0;
  logic        cfg_done, busy, err;
  logic [7:0]  err_cnt;
  logic [15:0] byte_cnt;

  uart_apb_ctrl_if bus();

  uart_apb_ctrl #(.DIV_RESET(DIV), .POLL_GAP(POLL_GAP), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .resetn(resetn), .en(en), .apb(bus.master),
    .cfg_done(cfg_done), .busy(busy), .err(err), .err_cnt(err_cnt), .byte_cnt(byte_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    logic        slverr;
  } xfer_t;

  xfer_t       sb_q[$];
  int          setup_log[$];
  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          exp_bytes = 0;
  int          exp_errs = 0;
  xfer_t       cur;
  int          cur_wait = 0;
  logic [31:0] s_addr, s_wdata;
  logic        s_wr;

  always @(posedge clk) cyc <= cyc + 1;

  // Slave model and scoreboard: pop an expectation at each setup phase,
  // then answer the access phase after the requested wait states.
  always @(negedge clk) begin
    bus.pready  = 1'b0;
    bus.pslverr = 1'b0;
    bus.prdata  = 32'h0;
    if (!resetn) begin
      cur_wait = 0;
    end else if (bus.psel && !bus.penable) begin
      setup_log.push_back(cyc);
      s_addr  = bus.paddr;
      s_wr    = bus.pwrite;
      s_wdata = bus.pwdata;
      n_chk++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_xfer addr %h wr %0b wdata %h required no transfer", bus.paddr, bus.pwrite, bus.pwdata);
        cur = '{addr: 32'h0, wr: 1'b0, wdata: 32'h0, rdata: 32'h0, waits: 0, slverr: 1'b0};
      end else begin
        cur = sb_q.pop_front();
        if (bus.paddr !== cur.addr || bus.pwrite !== cur.wr || bus.pprot !== 3'b000 ||
            bus.pstrb !== (cur.wr ? 4'hF : 4'h0) || (cur.wr && bus.pwdata !== cur.wdata)) begin
          n_err++;
          $display("FAIL xfer addr %h wr %0b wdata %h strb %h prot %0d required addr %h wr %0b wdata %h",
                   bus.paddr, bus.pwrite, bus.pwdata, bus.pstrb, bus.pprot, cur.addr, cur.wr, cur.wdata);
        end
      end
      cur_wait = cur.waits;
    end else if (bus.psel && bus.penable) begin
      n_chk++;
      if (bus.paddr !== s_addr || bus.pwrite !== s_wr || bus.pwdata !== s_wdata) begin
        n_err++;
        $display("FAIL access_stable addr %h wr %0b wdata %h required addr %h wr %0b wdata %h",
                 bus.paddr, bus.pwrite, bus.pwdata, s_addr, s_wr, s_wdata);
      end
      if (cur_wait > 0) begin
        cur_wait--;
      end else begin
        bus.pready  = 1'b1;
        bus.prdata  = cur.rdata;
        bus.pslverr = cur.slverr;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_x(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int waits, input logic slverr);
    xfer_t x;
    x = '{addr: addr, wr: wr, wdata: wdata, rdata: rdata, waits: waits, slverr: slverr};
    sb_q.push_back(x);
  endtask

  task automatic push_cfg();
    push_x(32'hC, 1'b1, {16'h0, DIV}, 32'h0, 0, 1'b0);
    push_x(32'h8, 1'b1, 32'h3, 32'h0, 0, 1'b0);
  endtask

  task automatic reset_assert();
    step();
    resetn = 1'b0;
    en = 1'b0;
    repeat (3) step();
    sb_q.delete();
    exp_bytes = 0;
    exp_errs = 0;
  endtask

  task automatic reset_release();
    resetn = 1'b1;
  endtask

  task automatic drain(input int budget, input string name);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      step();
      if (sb_q.size() == 0 && !bus.psel) begin
        ok = 1'b1;
        break;
      end
    end
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s_drain pending %0d required 0 within %0d cycles", name, sb_q.size(), budget);
    end
  endtask

  // Raise en until the first queued transfer is seen, then drop it again so
  // the DUT parks in RUN_WAIT once the queued sequence is finished.
  task automatic kick(input string name);
    int n;
    bit ok;
    n = sb_q.size();
    ok = 1'b0;
    en = 1'b1;
    for (int k = 0; k < 4 * POLL_GAP + 20; k++) begin
      step();
      if (sb_q.size() < n) begin
        ok = 1'b1;
        break;
      end
    end
    en = 1'b0;
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s_start no poll seen required poll", name);
    end
  endtask

  task automatic check_cnts(input string name);
    n_chk++;
    if (byte_cnt !== 16'(exp_bytes) || err_cnt !== 8'(exp_errs)) begin
      n_err++;
      $display("FAIL %s_cnts byte_cnt %0d err_cnt %0d required %0d %0d", name, byte_cnt, err_cnt, exp_bytes, exp_errs);
    end
  endtask

  task automatic test_reset();
    bit e_psel, e_pen, e_done;
    repeat (2) step();
    n_chk++;
    if (bus.psel !== 1'b0 || bus.penable !== 1'b0 || cfg_done !== 1'b0 || err !== 1'b0 ||
        err_cnt !== 8'h0 || byte_cnt !== 16'h0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs psel %b pen %b done %b err %b ecnt %0d bcnt %0d required all 0",
               bus.psel, bus.penable, cfg_done, err, err_cnt, byte_cnt);
    end
    push_cfg();
    reset_release();
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      e_psel = (i <= 4);
      e_pen  = (i == 2 || i == 4);
      e_done = (i == 5);
      n_chk++;
      if (bus.psel !== e_psel || bus.penable !== e_pen || cfg_done !== e_done) begin
        n_err++;
        $display("FAIL cfg_cycle%0d psel %b pen %b done %b required %b %b %b",
                 i, bus.psel, bus.penable, cfg_done, e_psel, e_pen, e_done);
      end
    end
    drain(20, "cfg");
    check_cnts("cfg");
  endtask

  task automatic test_echo();
    push_x(32'h4, 1'b0, 32'h0, 32'h1, 0, 1'b0);
    push_x(32'h0, 1'b0, 32'h0, 32'h5A, 1, 1'b0);
    push_x(32'h4, 1'b0, 32'h0, 32'h0, 0, 1'b0);
    push_x(32'h0, 1'b1, 32'h5A, 32'h0, 2, 1'b0);
    exp_bytes++;
    kick("echo");
    drain(100, "echo");
    check_cnts("echo");
  endtask

  task automatic test_tx_poll();
    setup_log.delete();
    push_x(32'h4, 1'b0, 32'h0, 32'h1, 0, 1'b0);
    push_x(32'h0, 1'b0, 32'h0, 32'hA5, 0, 1'b0);
    for (int i = 0; i < 3; i++) push_x(32'h4, 1'b0, 32'h0, 32'h2, 0, 1'b0);
    push_x(32'h4, 1'b0, 32'h0, 32'h0, 0, 1'b0);
    push_x(32'h0, 1'b1, 32'hA5, 32'h0, 0, 1'b0);
    exp_bytes++;
    kick("txpoll");
    drain(200, "txpoll");
    check_cnts("txpoll");
    n_chk++;
    if (setup_log.size() != 7) begin
      n_err++;
      $display("FAIL txpoll_count setups %0d required 7", setup_log.size());
    end else begin
      for (int i = 2; i < 5; i++) begin
        n_chk++;
        if (setup_log[i+1] - setup_log[i] != POLL_GAP + 2) begin
          n_err++;
          $display("FAIL txpoll_gap%0d spacing %0d required %0d", i, setup_log[i+1] - setup_log[i], POLL_GAP + 2);
        end
      end
      n_chk++;
      if (setup_log[6] - setup_log[5] != 2) begin
        n_err++;
        $display("FAIL txpoll_write spacing %0d required 2", setup_log[6] - setup_log[5]);
      end
    end
  endtask

  task automatic test_slverr();
    push_x(32'h4, 1'b0, 32'h0, 32'h1, 0, 1'b0);
    push_x(32'h0, 1'b0, 32'h0, 32'h33, 0, 1'b1);
    exp_errs++;
    kick("slverr");
    drain(100, "slverr");
    repeat (POLL_GAP + 4) step();
    check_cnts("slverr");
    n_chk++;
    if (err !== 1'b0) begin
      n_err++;
      $display("FAIL slverr_sticky err %b required 0", err);
    end
    push_x(32'h4, 1'b0, 32'h0, 32'h0, 0, 1'b0);
    kick("slverr_next");
    drain(50, "slverr_next");
  endtask

  task automatic test_enable();
    int sel_cnt;
    int lat;
    sel_cnt = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.psel) sel_cnt++;
    end
    n_chk++;
    if (sel_cnt != 0) begin
      n_err++;
      $display("FAIL en_low_idle psel cycles %0d required 0", sel_cnt);
    end
    push_x(32'h4, 1'b0, 32'h0, 32'h0, 0, 1'b0);
    step();
    en = 1'b1;
    lat = -1;
    for (int k = 1; k <= POLL_GAP + 4; k++) begin
      @(negedge clk);
      if (bus.psel) begin
        lat = k;
        break;
      end
    end
    step();
    en = 1'b0;
    n_chk++;
    if (lat < 1 || lat > POLL_GAP + 1) begin
      n_err++;
      $display("FAIL en_latency cycles %0d required 1..%0d", lat, POLL_GAP + 1);
    end
    drain(50, "en");
  endtask

  task automatic test_reset_mid();
    bit ok;
    push_x(32'h4, 1'b0, 32'h0, 32'h0, 10, 1'b0);
    en = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (bus.psel && bus.penable) begin
        ok = 1'b1;
        break;
      end
    end
    resetn = 1'b0;
    en = 1'b0;
    #1;
    n_chk++;
    if (!ok || bus.psel !== 1'b0 || bus.penable !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_drop psel %b pen %b seen_access %0d required 0 0 1", bus.psel, bus.penable, ok);
    end
    reset_assert();
    push_cfg();
    reset_release();
    drain(20, "reset_mid");
    n_chk++;
    if (cfg_done !== 1'b1 || err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_cfg done %b err %b required 1 0", cfg_done, err);
    end
    check_cnts("reset_mid");
  endtask

  task automatic test_cfg_err();
    int sel_cnt;
    reset_assert();
    push_x(32'hC, 1'b1, {16'h0, DIV}, 32'h0, 0, 1'b0);
    push_x(32'h8, 1'b1, 32'h3, 32'h0, 0, 1'b1);
    reset_release();
    drain(20, "cfg_err");
    n_chk++;
    if (err !== 1'b1 || cfg_done !== 1'b0) begin
      n_err++;
      $display("FAIL cfg_err_flags err %b done %b required 1 0", err, cfg_done);
    end
    en = 1'b1;
    sel_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.psel) sel_cnt++;
    end
    en = 1'b0;
    n_chk++;
    if (sel_cnt != 0) begin
      n_err++;
      $display("FAIL cfg_err_idle psel cycles %0d required 0", sel_cnt);
    end
  endtask

  task automatic test_timeout();
    int acc;
    int sel_cnt;
    bit done;
    reset_assert();
    push_x(32'hC, 1'b1, {16'h0, DIV}, 32'h0, 1000, 1'b0);
    reset_release();
    acc = 0;
    done = 1'b0;
    for (int k = 0; k < 3 * TIMEOUT; k++) begin
      @(negedge clk);
      if (bus.psel && bus.penable) acc++;
      else if (!bus.psel && acc > 0) begin
        done = 1'b1;
        break;
      end
    end
    n_chk++;
    if (!done || acc != TIMEOUT) begin
      n_err++;
      $display("FAIL timeout_len access cycles %0d dropped %0d required %0d 1", acc, done, TIMEOUT);
    end
    n_chk++;
    if (err !== 1'b1 || cfg_done !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_flags err %b done %b required 1 0", err, cfg_done);
    end
    en = 1'b1;
    sel_cnt = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.psel) sel_cnt++;
    end
    en = 1'b0;
    n_chk++;
    if (sel_cnt != 0) begin
      n_err++;
      $display("FAIL timeout_idle psel cycles %0d required 0", sel_cnt);
    end
    reset_assert();
    push_cfg();
    reset_release();
    drain(20, "recover");
    n_chk++;
    if (cfg_done !== 1'b1 || err !== 1'b0) begin
      n_err++;
      $display("FAIL recover_flags done %b err %b required 1 0", cfg_done, err);
    end
  endtask

  initial begin
    test_reset();
    test_echo();
    test_tx_poll();
    test_slverr();
    test_enable();
    test_reset_mid();
    test_cfg_err();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
